// File: rtl/spi_rx_pkg.sv
// Shared definitions for the SPI frame receiver.
// Contents: receiver FSM state encoding, err_status bit indices, default
// frame geometry and write-target encoding.
package spi_rx_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StShift   = 2'd1,
        StWaitEnd = 2'd2,
        StDrain   = 2'd3
    } rx_state_e;

    // Default frame geometry: {data[7:0], addr[3:0]}, sent LSB-first.
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 4;
    localparam int unsigned FRAME_W    = DATA_W_DEF + ADDR_W_DEF;

    // err_status bit positions (sticky flags).
    localparam int unsigned ERR_SHORT    = 0;
    localparam int unsigned ERR_LONG     = 1;
    localparam int unsigned ERR_OVERRUN  = 2;
    localparam int unsigned ERR_CONFLICT = 3;
    localparam int unsigned ERR_W        = 4;

    // wr_target encoding.
    localparam logic TARGET_ICACHE = 1'b0;
    localparam logic TARGET_DCACHE = 1'b1;

endpackage

// File: rtl/spi_rx_hold.sv
// Single-entry valid/ready holding register for received write requests.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   commit              a validated frame is offered this cycle
//   commit_target/addr/data  fields of the offered frame
//   wr_ready            consumer accepts the held request this cycle
//   wr_valid/target/addr/data  held request, stable until accepted
//   overrun             offered frame dropped because the entry is full
module spi_rx_hold #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit,
    input  logic              commit_target,
    input  logic [ADDR_W-1:0] commit_addr,
    input  logic [DATA_W-1:0] commit_data,
    input  logic              wr_ready,
    output logic              wr_valid,
    output logic              wr_target,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              overrun
);

    logic              valid_q;
    logic              target_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Entry stays occupied when not drained this cycle; a new frame then has nowhere to go.
    assign overrun = commit & valid_q & ~wr_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            target_q <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
        end else if (commit && !overrun) begin
            // Covers both an empty entry and accept-plus-refill on the same edge.
            valid_q  <= 1'b1;
            target_q <= commit_target;
            addr_q   <= commit_addr;
            data_q   <= commit_data;
        end else if (valid_q && wr_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign wr_valid  = valid_q;
    assign wr_target = target_q;
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;

endmodule

// File: rtl/spi_frame_rx.sv
// Slave-side SPI receive front end for the processor load path.
// Samples mosi on clk under csi_n (icache) or csd_n (dcache), deserialises
// LSB-first {data, addr} frames, validates framing and offers each good frame
// as a valid/ready write request.
// Ports:
//   clk, rst_n          processor clock, asynchronous active-low reset
//   csi_n, csd_n        instruction / data chip selects, active low
//   mosi                serial data, addr[0] first, data[MSB] last
//   proc_en             processor running: aborts and blocks reception
//   wr_valid/wr_ready   write request handshake
//   wr_target           0 = icache, 1 = dcache
//   wr_addr, wr_data    write request fields
//   busy                a frame is in progress or being drained
//   err_status          sticky {cs_conflict, overrun, long, short}
//   err_clr             clears err_status (new errors on the same edge win)
module spi_frame_rx
    import spi_rx_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csi_n,
    input  logic              csd_n,
    input  logic              mosi,
    input  logic              proc_en,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              wr_target,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic [3:0]        err_status,
    input  logic              err_clr
);

    localparam int unsigned FRAME_BITS = DATA_W + ADDR_W;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

    rx_state_e             state_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [FRAME_BITS-1:0] shift_q;
    logic                  target_q;
    logic [ERR_W-1:0]      err_q;
    logic [ERR_W-1:0]      err_set;

    logic sel_i, sel_d, one_sel, conflict, cs_lat, commit, overrun;

    assign sel_i    = ~csi_n;
    assign sel_d    = ~csd_n;
    assign one_sel  = sel_i ^ sel_d;
    assign conflict = sel_i & sel_d;
    // Chip select belonging to the frame in flight.
    assign cs_lat   = (target_q == TARGET_DCACHE) ? sel_d : sel_i;

    // Exactly FRAME_BITS bits seen and the select released cleanly.
    assign commit = (state_q == StWaitEnd) & ~proc_en & ~conflict & ~cs_lat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            target_q  <= TARGET_ICACHE;
        end else if (proc_en) begin
            state_q   <= StIdle;
            bit_cnt_q <= '0;
        end else if (conflict && state_q != StDrain) begin
            state_q   <= StDrain;
            bit_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (one_sel) begin
                        shift_q   <= {mosi, shift_q[FRAME_BITS-1:1]};
                        bit_cnt_q <= CNT_W'(1);
                        target_q  <= sel_d ? TARGET_DCACHE : TARGET_ICACHE;
                        state_q   <= StShift;
                    end
                end
                StShift: begin
                    if (cs_lat) begin
                        shift_q   <= {mosi, shift_q[FRAME_BITS-1:1]};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                            state_q <= StWaitEnd;
                        end
                    end else begin
                        // Short frame; if the other select is already low this was a
                        // CS switch, so wait for both to release.
                        bit_cnt_q <= '0;
                        state_q   <= (sel_i | sel_d) ? StDrain : StIdle;
                    end
                end
                StWaitEnd: begin
                    bit_cnt_q <= '0;
                    state_q   <= cs_lat ? StDrain : StIdle;
                end
                StDrain: begin
                    if (!sel_i && !sel_d) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Error events detected this cycle, mirroring the transition priorities above.
    always_comb begin
        err_set = '0;
        if (!proc_en) begin
            if (conflict && state_q != StDrain) begin
                err_set[ERR_CONFLICT] = 1'b1;
            end else if (state_q == StShift && !cs_lat) begin
                err_set[ERR_SHORT] = 1'b1;
            end else if (state_q == StWaitEnd && cs_lat) begin
                err_set[ERR_LONG] = 1'b1;
            end
        end
        err_set[ERR_OVERRUN] = overrun;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else begin
            err_q <= (err_clr ? '0 : err_q) | err_set;
        end
    end

    spi_rx_hold #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_hold (
        .clk           (clk),
        .rst_n         (rst_n),
        .commit        (commit),
        .commit_target (target_q),
        .commit_addr   (shift_q[ADDR_W-1:0]),
        .commit_data   (shift_q[FRAME_BITS-1:ADDR_W]),
        .wr_ready      (wr_ready),
        .wr_valid      (wr_valid),
        .wr_target     (wr_target),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .overrun       (overrun)
    );

    assign busy       = (state_q != StIdle);
    assign err_status = err_q;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed self-checking bench for spi_frame_rx.
module tb_spi_frame_rx;

    logic       clk;
    logic       rst_n;
    logic       csi_n;
    logic       csd_n;
    logic       mosi;
    logic       proc_en;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_target;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic [3:0] err_status;
    logic       err_clr;

    int checks   = 0;
    int failures = 0;

    spi_frame_rx #(
        .DATA_W (8),
        .ADDR_W (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .csi_n      (csi_n),
        .csd_n      (csd_n),
        .mosi       (mosi),
        .proc_en    (proc_en),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_target  (wr_target),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .err_status (err_status),
        .err_clr    (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_req(input string tag, input logic v, input logic t,
                           input logic [3:0] a, input logic [7:0] d);
        chk({tag, "_valid"},  32'(wr_valid),  32'(v));
        chk({tag, "_target"}, 32'(wr_target), 32'(t));
        chk({tag, "_addr"},   32'(wr_addr),   32'(a));
        chk({tag, "_data"},   32'(wr_data),   32'(d));
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive n bits LSB-first under one chip select, one bit per clock.
    task automatic shift_bits(input logic dcache, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            csi_n = dcache;
            csd_n = ~dcache;
            mosi  = bits[i];
            tick();
        end
    endtask

    task automatic cs_release();
        csi_n = 1'b1;
        csd_n = 1'b1;
        mosi  = 1'b0;
        tick();
    endtask

    task automatic clear_errors();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        csi_n    = 1'b1;
        csd_n    = 1'b1;
        mosi     = 1'b0;
        proc_en  = 1'b0;
        wr_ready = 1'b1;
        err_clr  = 1'b0;
        #12;
        chk_req("rst", 1'b0, 1'b0, 4'h0, 8'h00);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_status), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Icache frame: data 0xA5 to addr 0x3.
        shift_bits(1'b0, 16'h0A53, 12);
        chk("t1_busy_after_last_bit", 32'(busy), 32'd1);
        chk("t1_no_valid_yet", 32'(wr_valid), 32'd0);
        cs_release();
        chk_req("t1_commit", 1'b1, 1'b0, 4'h3, 8'hA5);
        chk("t1_busy_idle", 32'(busy), 32'd0);
        chk("t1_err", 32'(err_status), 32'd0);
        tick();
        chk("t1_valid_one_cycle", 32'(wr_valid), 32'd0);

        // Dcache frame 0x7F to addr 0xE under backpressure.
        wr_ready = 1'b0;
        shift_bits(1'b1, 16'h07FE, 12);
        cs_release();
        chk_req("t2_commit", 1'b1, 1'b1, 4'hE, 8'h7F);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_req("t2_hold", 1'b1, 1'b1, 4'hE, 8'h7F);
        end
        wr_ready = 1'b1;
        tick();
        chk("t2_drop_after_ready", 32'(wr_valid), 32'd0);

        // Short frame (9 bits), then long frame (14 bits), then clear.
        shift_bits(1'b0, 16'h01FF, 9);
        cs_release();
        chk("t3_short_err", 32'(err_status), 32'h1);
        chk("t3_short_nowr", 32'(wr_valid), 32'd0);
        chk("t3_short_busy", 32'(busy), 32'd0);
        shift_bits(1'b0, 16'h3FFF, 14);
        chk("t3_long_draining", 32'(busy), 32'd1);
        cs_release();
        chk("t3_long_err", 32'(err_status), 32'h3);
        chk("t3_long_nowr", 32'(wr_valid), 32'd0);
        chk("t3_long_busy", 32'(busy), 32'd0);
        clear_errors();
        chk("t3_clr", 32'(err_status), 32'h0);

        // Overrun: two good frames back to back with no consumer.
        wr_ready = 1'b0;
        shift_bits(1'b0, 16'h0111, 12);
        cs_release();
        chk_req("t4_first", 1'b1, 1'b0, 4'h1, 8'h11);
        chk("t4_first_err", 32'(err_status), 32'h0);
        shift_bits(1'b1, 16'h0222, 12);
        cs_release();
        chk("t4_overrun_err", 32'(err_status), 32'h4);
        chk_req("t4_held", 1'b1, 1'b0, 4'h1, 8'h11);
        wr_ready = 1'b1;
        tick();
        chk("t4_drained", 32'(wr_valid), 32'd0);
        clear_errors();
        chk("t4_clr", 32'(err_status), 32'h0);

        // Chip-select conflict at bit 5 of an icache frame.
        shift_bits(1'b0, 16'h0FFF, 4);
        csi_n = 1'b0;
        csd_n = 1'b0;
        mosi  = 1'b1;
        tick();
        chk("t5_conflict_err", 32'(err_status), 32'h8);
        chk("t5_conflict_drain", 32'(busy), 32'd1);
        cs_release();
        chk("t5_conflict_idle", 32'(busy), 32'd0);
        chk("t5_conflict_nowr", 32'(wr_valid), 32'd0);
        clear_errors();
        chk("t5_clr", 32'(err_status), 32'h0);

        // proc_en abort at bit 6.
        shift_bits(1'b0, 16'h0FFF, 5);
        proc_en = 1'b1;
        mosi    = 1'b1;
        tick();
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_err", 32'(err_status), 32'h0);
        proc_en = 1'b0;
        cs_release();
        chk("t5_abort_nowr", 32'(wr_valid), 32'd0);
        chk("t5_abort_busy2", 32'(busy), 32'd0);

        // Async reset mid-frame with a request pending.
        wr_ready = 1'b0;
        shift_bits(1'b1, 16'h03C5, 12);
        cs_release();
        chk_req("t6_pending", 1'b1, 1'b1, 4'h5, 8'h3C);
        shift_bits(1'b0, 16'h00FF, 8);
        #2;
        rst_n = 1'b0;
        #1;
        chk_req("t6_async_rst", 1'b0, 1'b0, 4'h0, 8'h00);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_err", 32'(err_status), 32'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        wr_ready = 1'b1;
        csi_n    = 1'b1;
        csd_n    = 1'b1;
        tick();
        shift_bits(1'b1, 16'h0C39, 12);
        cs_release();
        chk_req("t6_fresh", 1'b1, 1'b1, 4'h9, 8'hC3);
        chk("t6_fresh_err", 32'(err_status), 32'h0);
        tick();
        chk("t6_fresh_drop", 32'(wr_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
